// File: rtl/link_idle_checker.sv
`default_nettype none
// ============================================================================
// Module   : link_idle_checker
// Purpose  : Downstream consumer of the data mux stream. Accepts every word,
//            classifies it as BX0-idle, idle or data, locks to the orbit by
//            tracking the BX0 marker every ORBIT_LEN accepted words, and keeps
//            saturating statistics counters for link bring-up and monitoring.
// Ports    : clk, reset            - stream clock, synchronous active-high reset
//            s_axis_tdata/tvalid   - incoming stream word and valid
//            s_axis_tready         - ready (1 from the first cycle after reset)
//            enable                - checker enable; 0 forces IDLE
//            clear_counters        - synchronous clear of all statistics
//            idle_word             - expected idle pattern
//            idle_word_BX0         - expected orbit-marker idle pattern
//            state, locked         - framing FSM state (0..3) and lock flag
//            bx_pos                - orbit position of the last accepted word
//            word/idle/bx0/err_count - saturating statistics counters
// Config   : IDLE_CHK_BITREV_EN - when defined, tdata is bit-reversed before
//            all comparisons.
// Revision : 1.0 - initial release
// ============================================================================
module link_idle_checker #(
   parameter int DATA_WIDTH   = 32,
   parameter int ORBIT_LEN    = 3564,
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_COUNT = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  enable,
   input  logic                  clear_counters,
   input  logic [DATA_WIDTH-1:0] idle_word,
   input  logic [DATA_WIDTH-1:0] idle_word_BX0,
   output logic [1:0]            state,
   output logic                  locked,
   output logic [11:0]           bx_pos,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic [CNT_WIDTH-1:0]  idle_count,
   output logic [CNT_WIDTH-1:0]  bx0_count,
   output logic [CNT_WIDTH-1:0]  err_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   localparam logic [11:0]          ORBIT_LAST = 12'(ORBIT_LEN - 1);
   localparam logic [8:0]           LOCK_THR   = 9'(LOCK_COUNT);
   localparam logic [7:0]           UNLOCK_THR = 8'(UNLOCK_COUNT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

   state_t          state_q;
   logic [8:0]      good_q;   // one extra bit so good+1 cannot wrap at 255
   logic [7:0]      miss_q;
   logic [DATA_WIDTH-1:0] word;

`ifdef IDLE_CHK_BITREV_EN
   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bitrev
      assign word[i] = s_axis_tdata[DATA_WIDTH-1-i];
   end
`else
   assign word = s_axis_tdata;
`endif

   logic        accept;
   logic        is_bx0;
   logic        is_idl;
   logic [11:0] next_pos;
   logic        expect_bx0;
   logic [8:0]  good_inc;
   logic [7:0]  miss_inc;
   logic        counting;
   logic        err_inc;

   assign accept     = s_axis_tvalid & s_axis_tready;
   assign is_bx0     = (word == idle_word_BX0);
   // BX0 has priority when both patterns happen to be equal
   assign is_idl     = !is_bx0 && (word == idle_word);
   assign next_pos   = (bx_pos == ORBIT_LAST) ? 12'd0 : bx_pos + 12'd1;
   assign expect_bx0 = (next_pos == 12'd0);
   assign good_inc   = good_q + 9'd1;
   assign miss_inc   = miss_q + 8'd1;
   assign counting   = accept && enable && (state_q != ST_IDLE);
   // Framing errors only matter once locked: a missing marker at the expected
   // slot, or a marker appearing anywhere else.
   assign err_inc    = counting && (state_q == ST_LOCKED) && (expect_bx0 != is_bx0);

   assign state = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         s_axis_tready <= 1'b0;
         locked        <= 1'b0;
         bx_pos        <= 12'd0;
         good_q        <= 9'd0;
         miss_q        <= 8'd0;
      end else begin
         s_axis_tready <= 1'b1;
         if (!enable) begin
            state_q <= ST_IDLE;
            locked  <= 1'b0;
            bx_pos  <= 12'd0;
            good_q  <= 9'd0;
            miss_q  <= 8'd0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_HUNT;
               end
               ST_HUNT: begin
                  if (accept) begin
                     if (is_bx0) begin
                        state_q <= ST_VERIFY;
                        bx_pos  <= 12'd0;
                        good_q  <= 9'd1;
                     end else begin
                        bx_pos  <= next_pos;
                     end
                  end
               end
               ST_VERIFY: begin
                  if (accept) begin
                     bx_pos <= next_pos;
                     if (expect_bx0) begin
                        if (is_bx0) begin
                           good_q <= good_inc;
                           // >= so LOCK_COUNT=1 still locks on the next marker
                           if (good_inc >= LOCK_THR) begin
                              state_q <= ST_LOCKED;
                              locked  <= 1'b1;
                              miss_q  <= 8'd0;
                           end
                        end else begin
                           state_q <= ST_HUNT;
                        end
                     end else if (is_bx0) begin
                        state_q <= ST_HUNT;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (accept) begin
                     // Position is never realigned to a misplaced marker
                     bx_pos <= next_pos;
                     if (expect_bx0) begin
                        if (is_bx0) begin
                           miss_q <= 8'd0;
                        end else begin
                           miss_q <= miss_inc;
                           if (miss_inc == UNLOCK_THR) begin
                              state_q <= ST_HUNT;
                              locked  <= 1'b0;
                           end
                        end
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Statistics: saturating, clear has priority over increment
   always_ff @(posedge clk) begin
      if (reset || clear_counters) begin
         word_count <= '0;
         idle_count <= '0;
         bx0_count  <= '0;
         err_count  <= '0;
      end else begin
         if (counting && word_count != CNT_MAX)
            word_count <= word_count + 1'b1;
         if (counting && is_idl && idle_count != CNT_MAX)
            idle_count <= idle_count + 1'b1;
         if (counting && is_bx0 && bx0_count != CNT_MAX)
            bx0_count <= bx0_count + 1'b1;
         if (err_inc && err_count != CNT_MAX)
            err_count <= err_count + 1'b1;
      end
   end

endmodule
`default_nettype wire
